// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT input/output reorder stages.
// Optional frame-boundary checking in the writer is enabled with FFT_INPUT_LAST_CHECK_EN.
package fft_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fft_in_state_t;

    function automatic int FRAME_LEN(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Reverses the low `width` bits of value; bits above width return zero.
    function automatic logic [15:0] bit_reverse(input logic [15:0] value, input int width);
        logic [15:0] result;
        result = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < width) begin
                result[i[3:0]] = value[4'(width - 1 - i)];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Combinational ADDR_WIDTH-bit address bit reverser, shared by the input writer
// and the output reorder stage.
module fft_bitrev_addr
    import fft_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    logic [15:0] w_rev;

    assign w_rev  = bit_reverse(16'(i_addr), ADDR_WIDTH);
    assign o_addr = w_rev[ADDR_WIDTH-1:0];

endmodule

// File: rtl/fft_input_writer.sv
// FFT input stage: writes a streamed frame into the sample RAM in bit-reversed order,
// then holds it until released. Define FFT_INPUT_LAST_CHECK_EN to add lastIn/frameErrOut.
module fft_input_writer
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clkIn,
    input  logic                  rstNIn,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  validIn,
    output logic                  readyOut,
    input  logic                  releaseIn,
    input  logic                  abortIn,
    output logic                  wrEnOut,
    output logic [ADDR_WIDTH-1:0] wrAddrOut,
    output logic [DATA_WIDTH-1:0] wrDataOut,
    output logic                  frameDoneOut,
`ifdef FFT_INPUT_LAST_CHECK_EN
    input  logic                  lastIn,
    output logic                  frameErrOut,
`endif
    output logic [ADDR_WIDTH:0]   fillCntOut
);

    localparam int                N       = FRAME_LEN(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] LP_LAST = (ADDR_WIDTH + 1)'(N - 1);

    fft_in_state_t           r_state;
    fft_in_state_t           w_state_next;
    logic [ADDR_WIDTH:0]     r_cnt;
    logic                    r_wr_en;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [DATA_WIDTH-1:0]   r_wr_data;
    logic                    r_frame_done;
    logic                    w_accept;
    logic                    w_take;
    logic                    w_last_idx;
    logic [ADDR_WIDTH-1:0]   w_rev_addr;

    // A sample accepted together with abortIn is dropped, so only w_take writes.
    assign w_accept   = validIn && (r_state == FILL);
    assign w_take     = w_accept && !abortIn;
    assign w_last_idx = (r_cnt == LP_LAST);

    fft_bitrev_addr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bitrev (
        .i_addr (r_cnt[ADDR_WIDTH-1:0]),
        .o_addr (w_rev_addr)
    );

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: next state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL:    if (w_take && w_last_idx) w_state_next = DRAIN;
            DRAIN:   w_state_next = HOLD;
            HOLD:    if (releaseIn) w_state_next = FILL;
            default: w_state_next = FILL;
        endcase
        if (abortIn) begin
            w_state_next = FILL;
        end
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            r_cnt        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (abortIn || (r_state == HOLD && releaseIn)) begin
                r_cnt <= '0;
            end else if (w_take) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_wr_en <= w_take;
            if (w_take) begin
                r_wr_addr <= w_rev_addr;
                r_wr_data <= dataIn;
            end
            // An abort in DRAIN lets the last write finish but never announces the frame.
            r_frame_done <= (r_state == DRAIN) && !abortIn;
        end
    end

`ifdef FFT_INPUT_LAST_CHECK_EN
    logic r_frame_err;

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_take && (lastIn != w_last_idx);
        end
    end

    assign frameErrOut = r_frame_err;
`endif

    assign readyOut     = (r_state == FILL);
    assign wrEnOut      = r_wr_en;
    assign wrAddrOut    = r_wr_addr;
    assign wrDataOut    = r_wr_data;
    assign frameDoneOut = r_frame_done;
    assign fillCntOut   = r_cnt;

endmodule
